// File: rtl/filter_coe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : filter_coe_ctrl
// Purpose  : Shadow/active coefficient banks for the 5x5 video convolution
//            filter. The active bank is swapped only at start-of-frame, and
//            the stream is stalled while the copy runs.
//            Optional macro COE_READBACK_EN adds a registered readback port.
// Revision : 1.0 - initial release
// ============================================================================
module filter_coe_ctrl #(
  parameter int FILTER_CORE_DIM = 5,
  parameter int COE_WIDTH       = 16,
  parameter int COE_ADDR_W      = 5
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [23:0]                                          s_axis_video_tdata,
  input  logic                                                 s_axis_video_tvalid,
  output logic                                                 s_axis_video_tready,
  input  logic                                                 s_axis_video_tuser,
  input  logic                                                 s_axis_video_tlast,
  output logic [23:0]                                          m_axis_video_tdata,
  output logic                                                 m_axis_video_tvalid,
  input  logic                                                 m_axis_video_tready,
  output logic                                                 m_axis_video_tuser,
  output logic                                                 m_axis_video_tlast,
  input  logic                                                 cfg_wr_en,
  input  logic [COE_ADDR_W-1:0]                                cfg_addr,
  input  logic [COE_WIDTH-1:0]                                 cfg_wdata,
  input  logic                                                 cfg_commit,
  output logic                                                 cfg_busy,
  output logic                                                 cfg_err,
  output logic                                                 coe_update,
  output logic [FILTER_CORE_DIM*FILTER_CORE_DIM*COE_WIDTH-1:0] coe_flat
`ifdef COE_READBACK_EN
  ,
  input  logic                                                 cfg_rd_en,
  input  logic                                                 cfg_rd_sel,
  output logic [COE_WIDTH-1:0]                                 cfg_rdata
`endif
);

  localparam int                    c_NN     = FILTER_CORE_DIM * FILTER_CORE_DIM;
  localparam int                    c_CENTRE = c_NN / 2;
  localparam logic [COE_WIDTH-1:0]  c_ONE    = {1'b0, {(COE_WIDTH-1){1'b1}}};
  localparam logic [COE_ADDR_W-1:0] c_LAST   = COE_ADDR_W'(c_NN - 1);
  localparam logic [COE_ADDR_W:0]   c_NN_W   = (COE_ADDR_W+1)'(c_NN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_LOAD    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [COE_WIDTH-1:0]  r_shadow [c_NN];
  logic [COE_WIDTH-1:0]  r_active [c_NN];
  logic [COE_ADDR_W-1:0] r_idx;
  logic                  r_recommit;
  logic                  r_release;
  logic                  r_update;
  logic                  r_err;
  logic                  w_sof;
  logic                  w_last;
  logic                  w_hold;
  logic                  w_addr_ok;
  logic                  w_wr_ok;
  logic                  w_wr_err;
  logic                  w_rd_err;

  assign w_sof     = s_axis_video_tvalid & s_axis_video_tuser;
  assign w_last    = (r_state == S_LOAD) && (r_idx == c_LAST);
  assign w_addr_ok = ({1'b0, cfg_addr} < c_NN_W);
  assign w_wr_ok   = cfg_wr_en & w_addr_ok & (r_state != S_LOAD);
  assign w_wr_err  = cfg_wr_en & (~w_addr_ok | (r_state == S_LOAD));

  // r_release masks the SOF beat held across the copy so it transfers
  // instead of re-triggering a load when a re-commit left us in PENDING.
  assign w_hold = (r_state == S_LOAD) |
                  ((r_state == S_PENDING) & w_sof & ~r_release);

  assign m_axis_video_tdata  = s_axis_video_tdata;
  assign m_axis_video_tuser  = s_axis_video_tuser;
  assign m_axis_video_tlast  = s_axis_video_tlast;
  assign m_axis_video_tvalid = s_axis_video_tvalid & ~w_hold;
  assign s_axis_video_tready = m_axis_video_tready & ~w_hold;

  assign cfg_busy   = (r_state == S_LOAD);
  assign cfg_err    = r_err;
  assign coe_update = r_update;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (cfg_commit) w_next = S_PENDING;
      S_PENDING: if (w_sof && !r_release) w_next = S_LOAD;
      S_LOAD:    if (w_last) w_next = (r_recommit || cfg_commit) ? S_PENDING : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_recommit <= 1'b0;
      r_release  <= 1'b0;
      r_update   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_update <= w_last;
      if (r_state == S_LOAD) r_idx <= w_last ? '0 : r_idx + 1'b1;
      else                   r_idx <= '0;
      if (r_state == S_LOAD) r_recommit <= w_last ? 1'b0 : (r_recommit | cfg_commit);
      else                   r_recommit <= 1'b0;
      if (w_last)                                          r_release <= 1'b1;
      else if (s_axis_video_tvalid && s_axis_video_tready) r_release <= 1'b0;
      if (w_wr_err || w_rd_err) r_err <= 1'b1;
    end
  end

  // Both banks come out of reset as the identity kernel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < c_NN; k++) begin
        r_shadow[k] <= (k == c_CENTRE) ? c_ONE : '0;
        r_active[k] <= (k == c_CENTRE) ? c_ONE : '0;
      end
    end else begin
      if (w_wr_ok) r_shadow[cfg_addr] <= cfg_wdata;
      if (r_state == S_LOAD) r_active[r_idx] <= r_shadow[r_idx];
    end
  end

  for (genvar k = 0; k < c_NN; k++) begin : g_flat
    assign coe_flat[k*COE_WIDTH +: COE_WIDTH] = r_active[k];
  end

`ifdef COE_READBACK_EN
  logic [COE_WIDTH-1:0] r_rdata;

  assign w_rd_err  = cfg_rd_en & ~w_addr_ok;
  assign cfg_rdata = r_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (cfg_rd_en) begin
      if (!w_addr_ok)      r_rdata <= '0;
      else if (cfg_rd_sel) r_rdata <= r_active[cfg_addr];
      else                 r_rdata <= r_shadow[cfg_addr];
    end
  end
`else
  assign w_rd_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_filter_coe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_coe_ctrl
// Purpose  : Randomised + directed bench for filter_coe_ctrl against an
//            event-level model of the coefficient banks and stream stall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_coe_ctrl;
  localparam int N  = 5;
  localparam int W  = 16;
  localparam int AW = 5;
  localparam int NN = N * N;
  localparam int FW = NN * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [23:0]   s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
  logic          s_tready;
  logic [23:0]   m_tdata;
  logic          m_tvalid, m_tuser, m_tlast;
  logic          m_tready = 1'b1;
  logic          cfg_wr_en = 1'b0, cfg_commit = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_wdata = '0;
  logic          cfg_busy, cfg_err, coe_update;
  logic [FW-1:0] coe_flat;
`ifdef COE_READBACK_EN
  logic          cfg_rd_en = 1'b0, cfg_rd_sel = 1'b0;
  logic [W-1:0]  cfg_rdata;
`endif

  always #5 clk = ~clk;

  filter_coe_ctrl #(.FILTER_CORE_DIM(N), .COE_WIDTH(W), .COE_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .s_axis_video_tdata(s_tdata), .s_axis_video_tvalid(s_tvalid),
    .s_axis_video_tready(s_tready), .s_axis_video_tuser(s_tuser),
    .s_axis_video_tlast(s_tlast),
    .m_axis_video_tdata(m_tdata), .m_axis_video_tvalid(m_tvalid),
    .m_axis_video_tready(m_tready), .m_axis_video_tuser(m_tuser),
    .m_axis_video_tlast(m_tlast),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .coe_update(coe_update), .coe_flat(coe_flat)
`ifdef COE_READBACK_EN
    , .cfg_rd_en(cfg_rd_en), .cfg_rd_sel(cfg_rd_sel), .cfg_rdata(cfg_rdata)
`endif
  );

  int tests = 0;
  int fails = 0;
  int pix = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_flat(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] ident_flat();
    logic [FW-1:0] r;
    r = '0;
    r[(NN/2)*W +: W] = 16'h7FFF;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  // Banks as arrays; a copy is an atomic bank assignment taking NN cycles of
  // stall after the triggering SOF beat is first presented.
  logic [W-1:0] ms [NN];
  logic [W-1:0] ma [NN];
  int  busy_cnt;
  bit  armed, recommit, rel_f, upd_exp, err_m;

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] r;
    for (int k = 0; k < NN; k++) r[k*W +: W] = ma[k];
    return r;
  endfunction

  function automatic bit model_hold();
    return (busy_cnt > 0) || (armed && s_tvalid && s_tuser && !rel_f);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NN; k++) begin
        ms[k] = (k == NN/2) ? 16'h7FFF : 16'h0000;
        ma[k] = ms[k];
      end
      busy_cnt = 0; armed = 0; recommit = 0; rel_f = 0; upd_exp = 0; err_m = 0;
    end else begin
      bit hold, xfer;
      hold = model_hold();
      xfer = s_tvalid && m_tready && !hold;
      upd_exp = 0;
      if (cfg_wr_en) begin
        if (busy_cnt > 0 || int'(cfg_addr) >= NN) err_m = 1;
        else ms[cfg_addr] = cfg_wdata;
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (cfg_commit) recommit = 1;
        if (busy_cnt == 0) begin
          for (int k = 0; k < NN; k++) ma[k] = ms[k];
          upd_exp = 1; rel_f = 1; armed = recommit; recommit = 0;
        end
      end else begin
        if (armed && s_tvalid && s_tuser && !rel_f) begin
          busy_cnt = NN; armed = 0;
        end else if (cfg_commit) begin
          armed = 1;
        end
        if (xfer) rel_f = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset) begin
      bit h;
      h = model_hold();
      chk("m_tvalid", 64'(m_tvalid), 64'(s_tvalid && !h));
      chk("s_tready", 64'(s_tready), 64'(m_tready && !h));
      chk("m_tdata",  64'(m_tdata),  64'(s_tdata));
      chk("m_tuser",  64'(m_tuser),  64'(s_tuser));
      chk("m_tlast",  64'(m_tlast),  64'(s_tlast));
      chk("cfg_busy", 64'(cfg_busy), 64'(busy_cnt > 0));
      chk("coe_update", 64'(coe_update), 64'(upd_exp));
      chk("cfg_err",  64'(cfg_err),  64'(err_m));
      if (busy_cnt == 0) chk_flat("coe_flat", coe_flat, model_flat());
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents an SOF beat and counts stalled cycles and update pulses until it is accepted.
  task automatic sof_run(input bit inject, output int stall, output int upd);
    stall = 0; upd = 0;
    s_tvalid = 1; s_tuser = 1; s_tlast = 0; s_tdata = 24'hABCDEF; m_tready = 1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (coe_update) upd++;
      if (s_tready) break;
      stall++;
      step();
      cfg_wr_en = 0; cfg_commit = 0;
      if (inject && i == 5) begin
        cfg_wr_en = 1; cfg_addr = 5'd2; cfg_wdata = 16'h7777; cfg_commit = 1;
      end
    end
    chk("sof_data", 64'(m_tdata), 64'h0000_0000_00AB_CDEF);
    chk("sof_user", 64'(m_tuser), 64'd1);
    step();
    s_tvalid = 0; s_tuser = 0; cfg_wr_en = 0; cfg_commit = 0;
  endtask

  task automatic run_rand(input int cycles, input bit cfg_on);
    bit acc;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      acc = s_tvalid && s_tready;
      step();
      if (acc) begin s_tvalid = 0; pix = (pix + 1) % 12; end
      if (!s_tvalid && $urandom_range(0, 9) < 7) begin
        s_tvalid = 1; s_tdata = 24'($urandom);
        s_tuser = (pix == 0); s_tlast = (pix % 4 == 3);
      end
      m_tready   = cfg_on ? ($urandom_range(0, 3) != 0) : 1'b1;
      cfg_wr_en  = cfg_on && ($urandom_range(0, 9) == 0);
      cfg_addr   = ($urandom_range(0, 99) == 0) ? AW'(25 + $urandom_range(0, 6))
                                                : AW'($urandom_range(0, 24));
      cfg_wdata  = W'($urandom);
      cfg_commit = cfg_on && ($urandom_range(0, 19) == 0);
    end
    step();
    s_tvalid = 0; s_tuser = 0; s_tlast = 0; cfg_wr_en = 0; cfg_commit = 0; m_tready = 1; pix = 0;
  endtask

  task automatic reset_pulse();
    reset = 0; step(); step(); reset = 1; step();
  endtask

  initial begin
    int st, up, up_tot;
    logic [FW-1:0] exp_flat;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    step();
    chk_flat("reset_flat", coe_flat, ident_flat());
    chk("reset_err", 64'(cfg_err), 64'd0);
    chk("reset_busy", 64'(cfg_busy), 64'd0);

    // Frame with no configuration: pure pass-through.
    run_rand(40, 1'b0);
    chk_flat("noconf_flat", coe_flat, ident_flat());

    // Write + commit in the same cycle, then SOF.
    cfg_wr_en = 1; cfg_addr = 5'd0; cfg_wdata = 16'h1000; cfg_commit = 1;
    step();
    cfg_wr_en = 0; cfg_commit = 0;
    step();
    sof_run(1'b0, st, up);
    chk("T2_stall", 64'(st), 64'd26);
    chk("T2_upd", 64'(up), 64'd1);
    chk("T2_coe0", 64'(coe_flat[15:0]), 64'h1000);
    chk("T2_centre", 64'(coe_flat[12*W +: W]), 64'h7FFF);

    // Commit mid-frame: beats keep flowing, bank unchanged until SOF.
    for (int b = 0; b < 6; b++) begin
      s_tvalid = 1; s_tuser = 0; s_tdata = 24'(b);
      cfg_wr_en = (b == 2); cfg_addr = 5'd1; cfg_wdata = 16'h0123; cfg_commit = (b == 3);
      @(negedge clk);
      chk("T3_ready", 64'(s_tready), 64'd1);
      chk("T3_coe1_old", 64'(coe_flat[W +: W]), 64'h0);
      step();
    end
    s_tvalid = 0; cfg_wr_en = 0; cfg_commit = 0;
    step();
    sof_run(1'b0, st, up);
    chk("T3_stall", 64'(st), 64'd26);
    chk("T3_coe1_new", 64'(coe_flat[W +: W]), 64'h0123);

    // Out-of-range write, write during LOAD, and re-commit during LOAD.
    cfg_wr_en = 1; cfg_addr = 5'd25; cfg_wdata = 16'hDEAD;
    step();
    cfg_wr_en = 0;
    @(negedge clk);
    chk("T4_err", 64'(cfg_err), 64'd1);
    step();
    cfg_commit = 1;
    step();
    cfg_commit = 0;
    sof_run(1'b1, st, up);
    up_tot = up;
    chk("T5_stall1", 64'(st), 64'd26);
    chk("T5_coe2_drop", 64'(coe_flat[2*W +: W]), 64'h0);
    repeat (3) step();
    chk("T5_idle_busy", 64'(cfg_busy), 64'd0);
    sof_run(1'b0, st, up);
    up_tot += up;
    chk("T5_stall2", 64'(st), 64'd26);
    chk("T5_upd_total", 64'(up_tot), 64'd2);
    chk("T5_err_sticky", 64'(cfg_err), 64'd1);
    exp_flat = ident_flat();
    exp_flat[0 +: W] = 16'h1000;
    exp_flat[W +: W] = 16'h0123;
    chk_flat("T5_flat", coe_flat, exp_flat);

    // Randomised traffic against the model.
    reset_pulse();
    run_rand(4000, 1'b1);

    // Reset asserted at LOAD index 12.
    reset_pulse();
    cfg_wr_en = 1; cfg_addr = 5'd3; cfg_wdata = 16'h2222; cfg_commit = 1;
    step();
    cfg_wr_en = 0; cfg_commit = 0;
    s_tvalid = 1; s_tuser = 1; s_tdata = 24'h123456; m_tready = 1;
    repeat (13) @(posedge clk);
    #2;
    chk("T6_busy_pre", 64'(cfg_busy), 64'd1);
    reset = 0;
    #1;
    chk("T6_busy", 64'(cfg_busy), 64'd0);
    chk("T6_upd", 64'(coe_update), 64'd0);
    chk("T6_err", 64'(cfg_err), 64'd0);
    chk("T6_ready", 64'(s_tready), 64'd1);
    chk_flat("T6_flat", coe_flat, ident_flat());
    s_tvalid = 0; s_tuser = 0;
    step();
    reset = 1;
    step();
    chk_flat("T6_flat_after", coe_flat, ident_flat());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

endmodule
`default_nettype wire
